meter_cmd_scheduler: RTL and testbench

METER_CMD_SCHEDULER -- requirements
Module: meter_cmd_scheduler

---
 rtl/meter_cmd_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_meter_cmd_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meter_cmd_scheduler.sv
// Debounced six-button command scheduler: per-button debounce, pending bits, preset-first arbiter,
// command FIFO. Define SCHED_ROUND_ROBIN_EN for round-robin add arbitration (fixed order otherwise).
module meter_cmd_scheduler #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add1,
    input  logic       add2,
    input  logic       add3,
    input  logic       add4,
    input  logic       rst1,
    input  logic       rst2,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [3:0] fifo_level,
    output logic [7:0] drop_cnt
);
    localparam int NumCh = 6;
    localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] DebLast = 8'(DEB_CYCLES - 1);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    logic [NumCh-1:0] raw;
    logic [NumCh-1:0] sync1_q, sync2_q;
    logic [NumCh-1:0] deb_q, deb_d, deb_prev_q;
    logic [NumCh-1:0] arm_q, arm_d, evt_q;
    logic [7:0]       deb_cnt_q [NumCh];
    logic [7:0]       deb_cnt_d [NumCh];
    logic [1:0]       warm_q;

    logic [NumCh-1:0] pending_q, pending_d, clr;
    logic [NumCh-1:0] grant;
    logic [2:0]       grant_code;
    logic             is_preset, pop, push, retain, full;

    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  rd_q, rd_d, wr_q, wr_d, wr_idx;
    logic [3:0]       level_q, level_d;
    logic             valid_q, valid_d;
    logic [2:0]       code_q, code_d, head_d;
    logic [7:0]       drop_q, drop_d;
    logic [8:0]       drop_sum;

`ifdef SCHED_ROUND_ROBIN_EN
    logic [1:0] rr_q, rr_d;
`endif

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign raw = {rst2, rst1, add4, add3, add2, add1};

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NumCh; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DebLast) deb_d[i] = sync2_q[i];
                else                         deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
            end
        end
    end

    // A channel arms only once it has been seen released, so a button held through reset is ignored.
    assign arm_d = arm_q | ({NumCh{warm_q == 2'd2}} & ~sync2_q & ~deb_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            arm_q      <= '0;
            evt_q      <= '0;
            warm_q     <= '0;
            for (int i = 0; i < NumCh; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            arm_q      <= arm_d;
            evt_q      <= deb_q & ~deb_prev_q & arm_q;
            warm_q     <= (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
            for (int i = 0; i < NumCh; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    always_comb begin
        grant = '0;
        if (pending_q[4]) begin
            grant[4] = 1'b1;
        end else if (pending_q[5]) begin
            grant[5] = 1'b1;
        end else begin
`ifdef SCHED_ROUND_ROBIN_EN
            for (int k = 1; k <= 4; k++) begin
                if (grant[3:0] == '0 && pending_q[2'(rr_q + 2'(k))]) grant[2'(rr_q + 2'(k))] = 1'b1;
            end
`else
            for (int i = 3; i >= 0; i--) begin
                if (pending_q[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
`endif
        end
        grant_code = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (grant[i]) grant_code = 3'(i + 1);
        end
    end

    assign is_preset = grant[4] | grant[5];
    assign pop       = valid_q & cmd_ready;
    assign retain    = valid_q & ~cmd_ready;
    assign full      = (level_q == 4'(FIFO_DEPTH));
    assign push      = (|grant) & (~full | pop);
    assign rd_d      = rd_q + PtrW'(pop);

    always_comb begin
        if (push && is_preset) begin
            // Preset keeps only a head that is stalled on the meter, then queues behind it.
            wr_idx  = rd_d + PtrW'(retain);
            wr_d    = wr_idx + PtrW'(1);
            level_d = retain ? 4'd2 : 4'd1;
        end else if (push) begin
            wr_idx  = wr_q;
            wr_d    = wr_q + PtrW'(1);
            level_d = level_q + 4'd1 - 4'(pop);
        end else begin
            wr_idx  = wr_q;
            wr_d    = wr_q;
            level_d = level_q - 4'(pop);
        end
        head_d  = (push && wr_idx == rd_d) ? grant_code : mem_q[rd_d];
        valid_d = (level_d != 4'd0);
        code_d  = valid_d ? head_d : 3'd0;
    end

    always_comb begin
        clr = push ? grant : '0;
        if (push && is_preset) clr[3:0] = '1;
        pending_d = (pending_q & ~clr) | evt_q;
        drop_sum  = {1'b0, drop_q};
        for (int i = 0; i < NumCh; i++) begin
            drop_sum = drop_sum + 9'(evt_q[i] & pending_q[i]);
        end
        drop_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

`ifdef SCHED_ROUND_ROBIN_EN
    always_comb begin
        rr_d = rr_q;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (grant[i]) rr_d = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= grant_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            drop_q    <= drop_d;
        end
    end

    assign cmd_valid  = valid_q;
    assign cmd_code   = code_q;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_meter_cmd_scheduler.sv
// Bench for meter_cmd_scheduler: directed scenarios plus a randomized run compared each cycle
// against a behavioural model of debounce, pending/drop bookkeeping, arbitration and the queue.
`timescale 1ns/1ps
module tb_meter_cmd_scheduler;
    localparam int DEB = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       add1 = 1'b0, add2 = 1'b0, add3 = 1'b0, add4 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [3:0] fifo_level;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    meter_cmd_scheduler #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .add1(add1), .add2(add2), .add3(add3), .add4(add4), .rst1(rst1), .rst2(rst2),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: a level is accepted after DEB equal raw samples; a press reaches the
    // pending set four edges after the sample that completes it.
    bit [5:0]    m_deb, m_arm, m_runval, m_pend;
    int          m_run [6];
    bit [5:0]    m_pipe [4];
    int unsigned m_q [$];
    int          m_drop, m_last;

    always @(posedge clk or negedge rst) begin
        bit [5:0] raw_s, ev, ev_apply, clr;
        int  g, c, nd;
        bit  pop, retain, can;
        if (!rst) begin
            m_deb = '0; m_arm = '0; m_runval = '0; m_pend = '0;
            m_drop = 0; m_last = 0; m_q.delete();
            for (int i = 0; i < 6; i++) m_run[i] = 0;
            for (int i = 0; i < 4; i++) m_pipe[i] = '0;
        end else begin
            raw_s = {rst2, rst1, add4, add3, add2, add1};
            ev = '0;
            for (int i = 0; i < 6; i++) begin
                if (raw_s[i] == m_runval[i]) m_run[i]++;
                else begin m_runval[i] = raw_s[i]; m_run[i] = 1; end
                if (m_run[i] == DEB && m_runval[i] != m_deb[i]) begin
                    m_deb[i] = m_runval[i];
                    if (m_deb[i] && m_arm[i]) ev[i] = 1'b1;
                end
                if (!raw_s[i] && !m_deb[i]) m_arm[i] = 1'b1;
            end
            ev_apply = m_pipe[3];
            m_pipe[3] = m_pipe[2]; m_pipe[2] = m_pipe[1]; m_pipe[1] = m_pipe[0]; m_pipe[0] = ev;

            pop    = (m_q.size() > 0) && cmd_ready;
            retain = (m_q.size() > 0) && !cmd_ready;
            g = -1;
            if (m_pend[4]) g = 4;
            else if (m_pend[5]) g = 5;
            else begin
`ifdef SCHED_ROUND_ROBIN_EN
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (g < 0 && m_pend[c]) g = c;
                end
`else
                for (int k = 3; k >= 0; k--) if (m_pend[k]) g = k;
`endif
            end
            can = (m_q.size() < DEPTH) || pop;
            clr = '0;
            if (pop) void'(m_q.pop_front());
            if (g >= 0 && can) begin
                if (g >= 4) begin
                    if (retain) begin
                        while (m_q.size() > 1) void'(m_q.pop_back());
                    end else m_q.delete();
                    clr = 6'b001111;
                end else m_last = g;
                clr[g] = 1'b1;
                m_q.push_back(g + 1);
            end
            nd = 0;
            for (int i = 0; i < 6; i++) if (ev_apply[i] && m_pend[i]) nd++;
            m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
            m_pend = (m_pend & ~clr) | ev_apply;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int ch, input logic v);
        case (ch)
            0: add1 = v;
            1: add2 = v;
            2: add3 = v;
            3: add4 = v;
            4: rst1 = v;
            default: rst2 = v;
        endcase
    endtask

    task automatic press(input int ch);
        set_btn(ch, 1'b1);
        tick(6);
        set_btn(ch, 1'b0);
        tick(6);
    endtask

    task automatic do_reset();
        @(negedge clk);
        {add1, add2, add3, add4, rst1, rst2} = '0;
        cmd_ready = 1'b1;
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
        checks++; if (cmd_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", cmd_code); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        tick(3);
        rst = 1'b1;
        tick(12);
        checks++; if (cmd_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL post_reset_idle got valid=%b level=%0d want 0/0", cmd_valid, fifo_level);
        end
    endtask

    task automatic test_single_press();
        bit exp_v;
        do_reset();
        add2 = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            exp_v = (n == DEB + 4);
            checks++; if (cmd_valid !== exp_v) begin
                errors++; $display("FAIL single_press_valid edge k+%0d got %b want %b", n, cmd_valid, exp_v);
            end
            checks++; if (cmd_code !== (exp_v ? 3'd2 : 3'd0)) begin
                errors++; $display("FAIL single_press_code edge k+%0d got %0d want %0d", n, cmd_code, exp_v ? 2 : 0);
            end
            if (n == 9) add2 = 1'b0;
        end
    endtask

    task automatic test_bounce();
        bit seen;
        do_reset();
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            add1 = ((n / 3) % 2 == 0);
            @(negedge clk);
            if (cmd_valid) seen = 1'b1;
        end
        add1 = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bounce_valid got 1 want 0"); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL bounce_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_back_to_back();
        int first, second, t;
`ifdef SCHED_ROUND_ROBIN_EN
        first = 4; second = 1;
`else
        first = 1; second = 4;
`endif
        do_reset();
        add1 = 1'b1; add4 = 1'b1;
        t = 0;
        while (!cmd_valid && t < 30) begin
            @(negedge clk);
            t++;
            if (t == 8) begin add1 = 1'b0; add4 = 1'b0; end
        end
        add1 = 1'b0; add4 = 1'b0;
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'(first)) begin
            errors++; $display("FAIL b2b_first got valid=%b code=%0d want 1/%0d", cmd_valid, cmd_code, first);
        end
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'(second)) begin
            errors++; $display("FAIL b2b_second got valid=%b code=%0d want 1/%0d", cmd_valid, cmd_code, second);
        end
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", cmd_valid); end
    endtask

    task automatic test_backpressure();
        int cnt;
        do_reset();
        cmd_ready = 1'b0;
        for (int p = 0; p < 6; p++) press(2);
        tick(10);
        checks++; if (fifo_level !== 4'd4) begin errors++; $display("FAIL bp_level got %0d want 4", fifo_level); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp_drop got %0d want 1", drop_cnt); end
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd3) begin
            errors++; $display("FAIL bp_head got valid=%b code=%0d want 1/3", cmd_valid, cmd_code);
        end
        cnt = 0;
        cmd_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (cmd_valid && cmd_code == 3'd3) cnt++;
            @(negedge clk);
        end
        checks++; if (cnt != 5) begin errors++; $display("FAIL bp_drain got %0d commands want 5", cnt); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL bp_empty got %0d want 0", fifo_level); end
    endtask

    task automatic test_preset();
        do_reset();
        cmd_ready = 1'b0;
        press(0); press(1); press(2);
        checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL preset_fill got %0d want 3", fifo_level); end
        press(5);
        tick(6);
        checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL preset_level got %0d want 2", fifo_level); end
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin
            errors++; $display("FAIL preset_head got valid=%b code=%0d want 1/1", cmd_valid, cmd_code);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd6) begin
            errors++; $display("FAIL preset_next got valid=%b code=%0d want 1/6", cmd_valid, cmd_code);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL preset_empty got valid=%b level=%0d want 0/0", cmd_valid, fifo_level);
        end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL preset_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        cmd_ready = 1'b0;
        press(0); press(1); press(2);
        checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL mid_fill got %0d want 3", fifo_level); end
        #2 rst = 1'b0;
        #1;
        checks++; if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
            errors++; $display("FAIL mid_valid got valid=%b code=%0d want 0/0", cmd_valid, cmd_code);
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL mid_level got %0d want 0", fifo_level); end
        @(negedge clk);
        rst = 1'b1;
        cmd_ready = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_after got a command want none"); end
    endtask

    task automatic test_held_at_reset();
        bit seen;
        int t;
        @(negedge clk);
        rst = 1'b0;
        add1 = 1'b1;
        cmd_ready = 1'b1;
        tick(3);
        rst = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL held_reset got a command want none"); end
        add1 = 1'b0;
        tick(10);
        add1 = 1'b1;
        t = 0;
        while (!cmd_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        add1 = 1'b0;
        checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin
            errors++; $display("FAIL held_repress got valid=%b code=%0d want 1/1", cmd_valid, cmd_code);
        end
        tick(10);
    endtask

    task automatic test_drop_saturation();
        do_reset();
        cmd_ready = 1'b0;
        for (int p = 1; p <= 70; p++) begin
            {add4, add3, add2, add1} = 4'hF;
            tick(7);
            {add4, add3, add2, add1} = 4'h0;
            tick(7);
            if (p == 5) begin
                checks++; if (drop_cnt !== 8'd12) begin errors++; $display("FAIL drop_multi got %0d want 12", drop_cnt); end
            end
        end
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
        checks++; if (fifo_level !== 4'd4 || cmd_code !== 3'd1) begin
            errors++; $display("FAIL drop_queue got level=%0d code=%0d want 4/1", fifo_level, cmd_code);
        end
    endtask

    task automatic test_random();
        int       cd [6];
        bit [5:0] lv;
        int       pct;
        logic [2:0] exp_code;
        do_reset();
        for (int i = 0; i < 6; i++) cd[i] = $urandom_range(5, 20);
        lv = '0;
        pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) pct = ((c / 250) % 3 == 0) ? 90 : ((c / 250) % 3 == 1) ? 15 : 55;
            exp_code = (m_q.size() > 0) ? 3'(m_q[0]) : 3'd0;
            checks++; if (cmd_valid !== (m_q.size() > 0)) begin
                errors++; $display("FAIL rand_valid cycle %0d got %b want %b", c, cmd_valid, m_q.size() > 0);
            end
            checks++; if (cmd_code !== exp_code) begin
                errors++; $display("FAIL rand_code cycle %0d got %0d want %0d", c, cmd_code, exp_code);
            end
            checks++; if (fifo_level !== 4'(m_q.size())) begin
                errors++; $display("FAIL rand_level cycle %0d got %0d want %0d", c, fifo_level, m_q.size());
            end
            checks++; if (drop_cnt !== 8'(m_drop)) begin
                errors++; $display("FAIL rand_drop cycle %0d got %0d want %0d", c, drop_cnt, m_drop);
            end
            for (int i = 0; i < 6; i++) begin
                if (cd[i] == 0) begin
                    lv[i] = ~lv[i];
                    cd[i] = (i >= 4 && !lv[i]) ? $urandom_range(40, 150) : $urandom_range(1, 12);
                end else cd[i]--;
            end
            {rst2, rst1, add4, add3, add2, add1} = lv;
            cmd_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
        end
        {rst2, rst1, add4, add3, add2, add1} = '0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_back_to_back();
        test_backpressure();
        test_preset();
        test_reset_mid();
        test_held_at_reset();
        test_drop_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
